// File: rtl/drv_keypad_pkg.sv
// drv_keypad_pkg: scan-state type and pin-polarity helper shared by the keypad scanner
`ifndef PULLUP
`define PULLUP 0
`endif
`ifndef PULLDOWN
`define PULLDOWN 1
`endif
package drv_keypad_pkg;
    typedef enum logic [1:0] {DRIVE, SAMPLE, GAP} scan_state_e;
    function automatic logic idle_level(input int mode);
        return (mode == `PULLDOWN) ? 1'b0 : 1'b1;
    endfunction
endpackage

// File: rtl/drv_keypad_sync.sv
// drv_keypad_sync: two-flop synchroniser with configurable width and reset value
module drv_keypad_sync #(
    parameter int                 p_width = 1,
    parameter logic [p_width-1:0] p_reset = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [p_width-1:0] i_d,
    output logic [p_width-1:0] o_q
);
    logic [p_width-1:0] meta_q;
    logic [p_width-1:0] sync_q;
    // two-stage capture of the asynchronous pad levels
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= p_reset;
            sync_q <= p_reset;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end
    assign o_q = sync_q;
endmodule

// File: rtl/drv_keypad_scan.sv
// drv_keypad_scan: column-strobing key-matrix scanner; define DRV_KEYPAD_GHOST_EN for ghost-frame rejection and o_ghost
module drv_keypad_scan
    import drv_keypad_pkg::*;
#(
    parameter int p_height = 4,
    parameter int p_width  = 4,
    parameter int p_settle = 8,
    parameter int p_mode   = `PULLUP
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [p_height-1:0] i_row,
    output logic [p_width-1:0]  o_col,
    output logic [p_width-1:0]  o_sw [p_height-1:0],
    output logic                o_frame
`ifdef DRV_KEYPAD_GHOST_EN
    ,
    output logic                o_ghost
`endif
);
    localparam logic                 idle_lvl = idle_level(p_mode);
    localparam int                   cnt_w    = (p_settle > 1) ? $clog2(p_settle) : 1;
    localparam int                   col_w    = (p_width > 1) ? $clog2(p_width) : 1;
    localparam logic [cnt_w-1:0]     cnt_last = cnt_w'(p_settle - 1);
    localparam logic [col_w-1:0]     col_last = col_w'(p_width - 1);
    localparam logic [p_width-1:0]   row_idle = {p_width{idle_lvl}};
    localparam logic [p_height-1:0]  rows_idle = {p_height{idle_lvl}};

    scan_state_e        state_q;
    logic [cnt_w-1:0]   cnt_q;
    logic [col_w-1:0]   col_q;
    logic [p_width-1:0] shadow_q [p_height-1:0];
    logic [p_width-1:0] shadow_d [p_height-1:0];
    logic [p_width-1:0] sw_q [p_height-1:0];
    logic               frame_q;
    logic [p_height-1:0] row_s;
    logic               commit;
    logic               ghost;

    drv_keypad_sync #(
        .p_width (p_height),
        .p_reset (rows_idle)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_row),
        .o_q   (row_s)
    );

    assign commit = (state_q == SAMPLE) && (col_q == col_last);

    // strobe the current column in DRIVE and SAMPLE; everything idle in GAP and while reset is held
    always_comb begin
        o_col = row_idle;
        for (int c = 0; c < p_width; c++)
            if (!i_rst && state_q != GAP && col_w'(c) == col_q) o_col[c] = ~idle_lvl;
    end

    // shadow image with the synchronised rows merged into the sampled column
    always_comb begin
        for (int r = 0; r < p_height; r++)
            for (int c = 0; c < p_width; c++)
                shadow_d[r][c] = (state_q == SAMPLE && col_w'(c) == col_q) ? row_s[r] : shadow_q[r][c];
    end

`ifdef DRV_KEYPAD_GHOST_EN
    logic [p_width-1:0] pressed [p_height-1:0];
    logic [p_width-1:0] both;
    logic               ghost_q;
    // a frame ghosts when two rows share at least two pressed columns
    always_comb begin
        ghost = 1'b0;
        both  = '0;
        for (int r = 0; r < p_height; r++) pressed[r] = shadow_d[r] ^ row_idle;
        for (int a = 0; a < p_height; a++)
            for (int b = a + 1; b < p_height; b++) begin
                both  = pressed[a] & pressed[b];
                ghost = ghost | (|(both & (both - p_width'(1))));
            end
    end
    // ghost flag pulses alongside the frame pulse it suppressed
    always_ff @(posedge i_clk) begin
        if (i_rst) ghost_q <= 1'b0;
        else       ghost_q <= commit && ghost;
    end
    assign o_ghost = ghost_q;
`else
    assign ghost = 1'b0;
`endif

    // scan sequencer: settle, sample, break-before-make gap per column; publish on the last column
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= DRIVE;
            cnt_q    <= '0;
            col_q    <= '0;
            shadow_q <= '{default: row_idle};
            sw_q     <= '{default: row_idle};
            frame_q  <= 1'b0;
        end else begin
            state_q  <= (state_q == DRIVE) ? ((cnt_q == cnt_last) ? SAMPLE : DRIVE) :
                        (state_q == SAMPLE) ? GAP : DRIVE;
            cnt_q    <= (state_q == DRIVE && cnt_q != cnt_last) ? cnt_q + cnt_w'(1) : '0;
            col_q    <= (state_q == GAP) ? ((col_q == col_last) ? '0 : col_q + col_w'(1)) : col_q;
            shadow_q <= shadow_d;
            frame_q  <= commit;
            if (commit && !ghost) sw_q <= shadow_d;
        end
    end

    assign o_sw    = sw_q;
    assign o_frame = frame_q;
endmodule

// File: tb/tb_drv_keypad_scan.sv
// tb_drv_keypad_scan: directed checks of strobe timing, frame commit, mid-frame reset, pull-down polarity and ghost rejection
`ifndef PULLUP
`define PULLUP 0
`endif
`ifndef PULLDOWN
`define PULLDOWN 1
`endif
module tb_drv_keypad_scan;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row, col, row_pd, col_pd;
    logic [3:0] sw [3:0];
    logic [3:0] sw_pd [3:0];
    logic       frame, frame_pd;
    logic [3:0] keys [4];
    logic [3:0] keys_pd [4];
    logic       seen;
    int         tests = 0;
    int         fails = 0;
`ifdef DRV_KEYPAD_GHOST_EN
    logic       ghost, ghost_pd;
`endif

    always #5 clk = ~clk;

    // passive matrix: a held key ties its row to the column strobe while that column is active
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row[r]    = ~|(keys[r] & ~col);
            row_pd[r] = |(keys_pd[r] & col_pd);
        end
    end

    drv_keypad_scan #(.p_height(4), .p_width(4), .p_settle(4), .p_mode(`PULLUP)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_row   (row),
        .o_col   (col),
        .o_sw    (sw),
        .o_frame (frame)
`ifdef DRV_KEYPAD_GHOST_EN
        ,
        .o_ghost (ghost)
`endif
    );

    drv_keypad_scan #(.p_height(4), .p_width(4), .p_settle(4), .p_mode(`PULLDOWN)) dut_pd (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_row   (row_pd),
        .o_col   (col_pd),
        .o_sw    (sw_pd),
        .o_frame (frame_pd)
`ifdef DRV_KEYPAD_GHOST_EN
        ,
        .o_ghost (ghost_pd)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        keys    = '{default: 4'h0};
        keys_pd = '{default: 4'h0};
        seen    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_col", 32'(col), 32'hF);
        check("rst_frame", 32'(frame), 32'h0);
        check("rst_sw", 32'({sw[3], sw[2], sw[1], sw[0]}), 32'hFFFF);
        check("rst_col_pd", 32'(col_pd), 32'h0);
        check("rst_sw_pd", 32'({sw_pd[3], sw_pd[2], sw_pd[1], sw_pd[0]}), 32'h0);
        keys[2]    = 4'b0010;
        keys_pd[0] = 4'b1000;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("c0_col", 32'(col), 32'hE);
        check("c0_col_pd", 32'(col_pd), 32'h1);
        tick(4);
        check("c4_col", 32'(col), 32'hE);
        tick(1);
        check("c5_gap_col", 32'(col), 32'hF);
        check("c5_gap_col_pd", 32'(col_pd), 32'h0);
        tick(1);
        check("c6_col", 32'(col), 32'hD);
        tick(12);
        check("c18_col", 32'(col), 32'h7);
        check("c18_col_pd", 32'(col_pd), 32'h8);
        tick(4);
        check("c22_frame", 32'(frame), 32'h0);
        check("c22_sw_old", 32'({sw[3], sw[2], sw[1], sw[0]}), 32'hFFFF);
        tick(1);
        check("c23_frame", 32'(frame), 32'h1);
        check("c23_sw_key21", 32'({sw[3], sw[2], sw[1], sw[0]}), 32'hFDFF);
        check("c23_frame_pd", 32'(frame_pd), 32'h1);
        check("c23_sw_pd_key03", 32'({sw_pd[3], sw_pd[2], sw_pd[1], sw_pd[0]}), 32'h0008);
        keys[2] = 4'b0000;
        tick(1);
        check("c24_frame", 32'(frame), 32'h0);
        check("c24_sw_hold", 32'({sw[3], sw[2], sw[1], sw[0]}), 32'hFDFF);
        tick(23);
        check("c47_frame", 32'(frame), 32'h1);
        check("c47_sw_nokeys", 32'({sw[3], sw[2], sw[1], sw[0]}), 32'hFFFF);
        keys[0] = 4'b0001;
        keys[3] = 4'b0101;
        tick(24);
        check("c71_frame", 32'(frame), 32'h1);
        check("c71_sw_multi", 32'({sw[3], sw[2], sw[1], sw[0]}), 32'hAFFE);
`ifdef DRV_KEYPAD_GHOST_EN
        check("c71_ghost", 32'(ghost), 32'h0);
`endif
        tick(16);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_sw", 32'({sw[3], sw[2], sw[1], sw[0]}), 32'hFFFF);
        check("midrst_col", 32'(col), 32'hF);
        check("midrst_frame", 32'(frame), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 23; i++) begin
            seen = seen | frame;
            tick(1);
        end
        check("midrst_no_early_frame", 32'(seen), 32'h0);
        check("midrst_c23_frame", 32'(frame), 32'h1);
        check("midrst_c23_sw", 32'({sw[3], sw[2], sw[1], sw[0]}), 32'hAFFE);
`ifdef DRV_KEYPAD_GHOST_EN
        keys[0] = 4'b0011;
        keys[1] = 4'b0011;
        keys[3] = 4'b0000;
        tick(24);
        check("ghost_flag", 32'(ghost), 32'h1);
        check("ghost_frame", 32'(frame), 32'h1);
        check("ghost_sw_kept", 32'({sw[3], sw[2], sw[1], sw[0]}), 32'hAFFE);
        keys[1] = 4'b0001;
        tick(24);
        check("noghost_flag", 32'(ghost), 32'h0);
        check("noghost_sw", 32'({sw[3], sw[2], sw[1], sw[0]}), 32'hFFEC);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
